// File: rtl/pacman_pkg.sv
// Shared types and helpers for the player direction/motion sequencer.
//   dir_t         : sprite heading (LEFT=0, RIGHT=1, DOWN=2, UP=3)
//   ctrl_state_t  : motion FSM states
//   motion_t      : per-frame signed X/Y step pair (10-bit two's complement)
//   KEY_*         : USB keycodes that select a direction
//   is_dir_key()  : 1 when a keycode maps to a direction
//   key2dir()     : keycode -> dir_t (only meaningful when is_dir_key() is 1)
//   opposite()    : reverse heading
//   dir2motion()  : heading + step size -> signed X/Y step
package pacman_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVING  = 2'd1,
    BLOCKED = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } motion_t;

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  function automatic logic is_dir_key(input logic [7:0] key);
    return (key == KEY_UP) || (key == KEY_DOWN) ||
           (key == KEY_LEFT) || (key == KEY_RIGHT);
  endfunction

  function automatic dir_t key2dir(input logic [7:0] key);
    dir_t d;
    case (key)
      KEY_UP:    d = UP;
      KEY_DOWN:  d = DOWN;
      KEY_RIGHT: d = RIGHT;
      default:   d = LEFT;
    endcase
    return d;
  endfunction

  function automatic dir_t opposite(input dir_t d);
    dir_t o;
    case (d)
      LEFT:    o = RIGHT;
      RIGHT:   o = LEFT;
      DOWN:    o = UP;
      default: o = DOWN;
    endcase
    return o;
  endfunction

  // Screen coordinates: +x is right, +y is down.
  function automatic motion_t dir2motion(input dir_t d, input logic [9:0] step);
    motion_t m;
    m = '0;
    case (d)
      LEFT:    m.x = -step;
      RIGHT:   m.x = step;
      DOWN:    m.y = step;
      default: m.y = -step;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pacman_dir_ctrl_if.sv
// Bundle between the keycode decoder / position register side (master) and
// the direction sequencer (slave).
//   keycode       : USB keycode for this frame
//   pause         : freeze request
//   pos_x, pos_y  : current sprite position
//   wall_u/d/l/r  : wall present in the adjacent tile in that direction
//   motion_x/y    : signed per-frame step back to the position datapath
//   facing        : current heading
//   moving        : sprite is in motion
//   turn_pending  : a buffered turn is waiting for alignment
interface pacman_dir_ctrl_if;
  import pacman_pkg::*;

  logic [7:0] keycode;
  logic       pause;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       wall_u;
  logic       wall_d;
  logic       wall_l;
  logic       wall_r;
  logic [9:0] motion_x;
  logic [9:0] motion_y;
  dir_t       facing;
  logic       moving;
  logic       turn_pending;

  modport master (
    output keycode, pause, pos_x, pos_y, wall_u, wall_d, wall_l, wall_r,
    input  motion_x, motion_y, facing, moving, turn_pending
  );

  modport slave (
    input  keycode, pause, pos_x, pos_y, wall_u, wall_d, wall_l, wall_r,
    output motion_x, motion_y, facing, moving, turn_pending
  );

endinterface

// File: rtl/turn_buffer.sv
// Timed turn buffer. Remembers the last direction key for TURN_TIMEOUT
// unpaused frames so a turn pressed slightly before a junction still happens.
//   frame_clk, Reset : frame clock, async active-high reset
//   enable           : 0 freezes the buffer (pause)
//   keycode          : this frame's keycode
//   consume          : the controller acted on req this frame; drop the buffer
//   req, req_v       : this frame's request (live key wins over buffered one)
//   pend_v           : registered "turn buffered" flag
module turn_buffer
  import pacman_pkg::*;
#(
  parameter int TURN_TIMEOUT = 16
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic [7:0] keycode,
  input  logic       consume,
  output dir_t       req,
  output logic       req_v,
  output logic       pend_v
);

  logic       key_v;
  dir_t       pend_dir;
  logic [7:0] pend_cnt;

  assign key_v = is_dir_key(keycode);
  assign req   = key_v ? key2dir(keycode) : pend_dir;
  assign req_v = key_v | pend_v;

  // Consume outranks capture: a key acted on in the same frame it arrives
  // must not linger in the buffer. Invalid keys only let the timer run.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      pend_dir <= LEFT;
      pend_cnt <= '0;
      pend_v   <= 1'b0;
    end else if (enable) begin
      if (consume) begin
        pend_cnt <= '0;
        pend_v   <= 1'b0;
      end else if (key_v) begin
        pend_dir <= key2dir(keycode);
        pend_cnt <= 8'(TURN_TIMEOUT);
        pend_v   <= 1'b1;
      end else if (pend_v) begin
        pend_cnt <= pend_cnt - 8'd1;
        if (pend_cnt == 8'd1) begin
          pend_v <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pacman_dir_ctrl.sv
// Player direction/motion sequencer. Turns W/A/S/D keys into per-frame signed
// motion, committing turns only at tile alignment with a clear wall probe,
// stopping at walls and pacing steps with a frame divider.
//   frame_clk : frame clock (one edge per video frame)
//   Reset     : asynchronous, active-high
//   bus       : pacman_dir_ctrl_if.slave (keys, pause, position, walls in;
//               motion, facing, moving, turn_pending out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset, never moved; waiting for a usable direction
//   MOVING  | stepping along facing on every step frame
//   BLOCKED | stopped aligned against a wall; buffered turn still kept
module pacman_dir_ctrl
  import pacman_pkg::*;
#(
  parameter int STEP         = 1,
  parameter int TILE_LOG2    = 3,
  parameter int ALIGN_OFS    = 0,
  parameter int TURN_TIMEOUT = 16,
  parameter int SPEED_DIV    = 1
) (
  input logic             frame_clk,
  input logic             Reset,
  pacman_dir_ctrl_if.slave bus
);

  localparam logic [9:0]           STEP_V  = 10'(STEP);
  localparam logic [TILE_LOG2-1:0] ALIGN_V = ALIGN_OFS[TILE_LOG2-1:0];
  localparam logic [3:0]           DIV_TOP = 4'(SPEED_DIV - 1);

  ctrl_state_t state;
  ctrl_state_t nxt_state;
  dir_t        facing_q;
  dir_t        nxt_facing;
  logic        moving_q;
  motion_t     motion_q;
  motion_t     nxt_motion;
  logic [3:0]  step_cnt;
  logic        step_frame;
  logic        consume;
  dir_t        req;
  logic        req_v;
  logic        pend_v;
  logic        aligned;
  logic [3:0]  walls;
  logic        unused_pos;

  // Indexed by dir_t: LEFT=0, RIGHT=1, DOWN=2, UP=3.
  assign walls = {bus.wall_u, bus.wall_d, bus.wall_r, bus.wall_l};

  assign aligned = (bus.pos_x[TILE_LOG2-1:0] == ALIGN_V) &&
                   (bus.pos_y[TILE_LOG2-1:0] == ALIGN_V);

  // Only the in-tile offset matters for alignment.
  assign unused_pos = ^{bus.pos_x[9:TILE_LOG2], bus.pos_y[9:TILE_LOG2]};

  assign step_frame = (step_cnt == 4'd0);

  turn_buffer #(
    .TURN_TIMEOUT(TURN_TIMEOUT)
  ) u_turn_buffer (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .enable   (~bus.pause),
    .keycode  (bus.keycode),
    .consume  (consume),
    .req      (req),
    .req_v    (req_v),
    .pend_v   (pend_v)
  );

  always_comb begin
    nxt_state  = state;
    nxt_facing = facing_q;
    consume    = 1'b0;
    if (step_frame && !bus.pause) begin
      case (state)
        IDLE, BLOCKED: begin
          if (req_v && !walls[req]) begin
            nxt_state  = MOVING;
            nxt_facing = req;
            consume    = 1'b1;
          end
        end
        MOVING: begin
          // Reversal is allowed anywhere; other turns wait for alignment.
          // A turn checked here wins over a wall ahead in the same frame.
          if (req_v && !walls[req] &&
              ((req == opposite(facing_q)) || ((req != facing_q) && aligned))) begin
            nxt_facing = req;
            consume    = 1'b1;
          end else begin
            // A repeat of the current heading is consumed, but it must not
            // carry the sprite through a wall.
            if (req_v && (req == facing_q)) begin
              consume = 1'b1;
            end
            if (aligned && walls[facing_q]) begin
              nxt_state = BLOCKED;
            end
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  assign nxt_motion = (step_frame && (nxt_state == MOVING)) ?
                      dir2motion(nxt_facing, STEP_V) : '0;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      facing_q <= LEFT;
      moving_q <= 1'b0;
      motion_q <= '0;
      step_cnt <= '0;
    end else if (bus.pause) begin
      motion_q <= '0;
    end else begin
      step_cnt <= (step_cnt == DIV_TOP) ? 4'd0 : step_cnt + 4'd1;
      state    <= nxt_state;
      facing_q <= nxt_facing;
      moving_q <= (nxt_state == MOVING);
      motion_q <= nxt_motion;
    end
  end

  assign bus.motion_x     = motion_q.x;
  assign bus.motion_y     = motion_q.y;
  assign bus.facing       = facing_q;
  assign bus.moving       = moving_q;
  assign bus.turn_pending = pend_v;

endmodule

// File: tb/tb_pacman_dir_ctrl.sv
// Bench for pacman_dir_ctrl: two instances (fast divider / long timeout and
// slow divider / short timeout) share keys, pause and walls; each has its own
// position integrated from its own motion output.
module tb_pacman_dir_ctrl;

  localparam int TO0 = 16;
  localparam int SD0 = 1;
  localparam int TO1 = 4;
  localparam int SD1 = 3;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] key;
  logic       pause;
  logic       wu, wd, wl, wr;
  logic [9:0] px [2];
  logic [9:0] py [2];

  int total = 0;
  int bad   = 0;

  pacman_dir_ctrl_if bus0 ();
  pacman_dir_ctrl_if bus1 ();

  assign bus0.keycode = key;
  assign bus0.pause   = pause;
  assign bus0.pos_x   = px[0];
  assign bus0.pos_y   = py[0];
  assign bus0.wall_u  = wu;
  assign bus0.wall_d  = wd;
  assign bus0.wall_l  = wl;
  assign bus0.wall_r  = wr;
  assign bus1.keycode = key;
  assign bus1.pause   = pause;
  assign bus1.pos_x   = px[1];
  assign bus1.pos_y   = py[1];
  assign bus1.wall_u  = wu;
  assign bus1.wall_d  = wd;
  assign bus1.wall_l  = wl;
  assign bus1.wall_r  = wr;

  pacman_dir_ctrl #(.TURN_TIMEOUT(TO0), .SPEED_DIV(SD0)) dut0 (
    .frame_clk(frame_clk), .Reset(Reset), .bus(bus0));
  pacman_dir_ctrl #(.TURN_TIMEOUT(TO1), .SPEED_DIV(SD1)) dut1 (
    .frame_clk(frame_clk), .Reset(Reset), .bus(bus1));

  always #5 frame_clk = ~frame_clk;

  // Reference model: heading as 0..3 (left,right,down,up), a moving flag,
  // an unpaused-frame counter, and the buffered key as (dir, capture frame).
  bit         m_go    [2];
  int         m_face  [2];
  int         m_frame [2];
  bit         m_plive [2];
  int         m_pdir  [2];
  int         m_pframe[2];
  logic [9:0] e_mx    [2];
  logic [9:0] e_my    [2];
  logic [1:0] e_face  [2];
  logic       e_mov   [2];
  logic       e_pend  [2];
  logic [9:0] o_mx    [2];
  logic [9:0] o_my    [2];
  logic [1:0] o_face  [2];
  logic       o_mov   [2];
  logic       o_tp    [2];

  function automatic int key_dir(input logic [7:0] k);
    case (k)
      8'h04:   return 0;
      8'h07:   return 1;
      8'h16:   return 2;
      8'h1A:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_go[i] = 1'b0; m_face[i] = 0; m_frame[i] = 0;
      m_plive[i] = 1'b0; m_pdir[i] = 0; m_pframe[i] = 0;
      e_mx[i] = '0; e_my[i] = '0; e_face[i] = '0; e_mov[i] = 1'b0; e_pend[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    int kd, rd, f, to, sd, dx, dy;
    bit have, al, stp, took;
    bit w [4];
    w[0] = wl; w[1] = wr; w[2] = wd; w[3] = wu;
    if (pause) begin
      e_mx[i] = '0;
      e_my[i] = '0;
      return;
    end
    to   = (i == 0) ? TO0 : TO1;
    sd   = (i == 0) ? SD0 : SD1;
    f    = m_frame[i];
    kd   = key_dir(key);
    have = (kd >= 0) || (m_plive[i] && ((f - m_pframe[i]) <= to));
    rd   = (kd >= 0) ? kd : m_pdir[i];
    stp  = (f % sd) == 0;
    al   = (int'(px[i]) % 8 == 0) && (int'(py[i]) % 8 == 0);
    took = 1'b0;
    if (stp) begin
      if (!m_go[i]) begin
        if (have && !w[rd]) begin
          m_go[i] = 1'b1; m_face[i] = rd; took = 1'b1;
        end
      end else if (have && !w[rd] &&
                   ((rd == (m_face[i] ^ 1)) || ((rd != m_face[i]) && al))) begin
        m_face[i] = rd; took = 1'b1;
      end else begin
        if (have && rd == m_face[i]) took = 1'b1;
        if (al && w[m_face[i]]) m_go[i] = 1'b0;
      end
    end
    if (took) m_plive[i] = 1'b0;
    else if (kd >= 0) begin
      m_pdir[i] = kd; m_pframe[i] = f; m_plive[i] = 1'b1;
    end
    e_pend[i] = m_plive[i] && ((f - m_pframe[i]) < to);
    dx = 0; dy = 0;
    if (stp && m_go[i]) begin
      case (m_face[i])
        0:       dx = -1;
        1:       dx = 1;
        2:       dy = 1;
        default: dy = -1;
      endcase
    end
    e_mx[i]    = 10'(dx);
    e_my[i]    = 10'(dy);
    e_face[i]  = 2'(m_face[i]);
    e_mov[i]   = m_go[i];
    m_frame[i] = f + 1;
  endtask

  task automatic chk(input string tag, input int inst,
                     input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic check_all();
    o_mx[0] = bus0.motion_x; o_my[0] = bus0.motion_y; o_face[0] = bus0.facing;
    o_mov[0] = bus0.moving;  o_tp[0] = bus0.turn_pending;
    o_mx[1] = bus1.motion_x; o_my[1] = bus1.motion_y; o_face[1] = bus1.facing;
    o_mov[1] = bus1.moving;  o_tp[1] = bus1.turn_pending;
    for (int i = 0; i < 2; i++) begin
      chk("motion_x", i, o_mx[i], e_mx[i]);
      chk("motion_y", i, o_my[i], e_my[i]);
      chk("facing", i, 10'(o_face[i]), 10'(e_face[i]));
      chk("moving", i, 10'(o_mov[i]), 10'(e_mov[i]));
      chk("turn_pending", i, 10'(o_tp[i]), 10'(e_pend[i]));
      px[i] = px[i] + o_mx[i];
      py[i] = py[i] + o_my[i];
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge frame_clk);
    #1;
    check_all();
  endtask

  task automatic reset_pulse(input logic [9:0] x0, input logic [9:0] y0);
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      px[i] = x0;
      py[i] = y0;
    end
  endtask

  logic [7:0] dk [4];
  int         nz;
  int         r;

  initial begin
    dk[0] = 8'h1A; dk[1] = 8'h16; dk[2] = 8'h04; dk[3] = 8'h07;
    Reset = 1'b1; key = 8'h00; pause = 1'b0;
    wu = 1'b0; wd = 1'b0; wl = 1'b0; wr = 1'b0;
    px[0] = 10'd64; py[0] = 10'd64; px[1] = 10'd64; py[1] = 10'd64;
    model_reset();

    // 1) start moving right on the first edge after reset
    reset_pulse(10'd64, 10'd64);
    chk("rst_facing", 0, 10'(o_face[0]), 10'd0);
    key = 8'h07;
    tick();
    chk("t1_moving", 0, 10'(o_mov[0]), 10'd1);
    chk("t1_facing", 0, 10'(o_face[0]), 10'd1);
    chk("t1_motion_x", 0, o_mx[0], 10'd1);
    chk("t1_motion_y", 0, o_my[0], 10'd0);

    // 2) buffered up-turn waits for alignment at x=72
    key = 8'h1A;
    tick();
    chk("t2_pend_set", 0, 10'(o_tp[0]), 10'd1);
    key = 8'h00;
    for (int n = 0; n < 20 && px[0] != 10'd72; n++) begin
      tick();
      chk("t2_pend_hold", 0, 10'(o_tp[0]), 10'd1);
    end
    chk("t2_reach72", 0, px[0], 10'd72);
    tick();
    chk("t2_facing", 0, 10'(o_face[0]), 10'd3);
    chk("t2_motion_y", 0, o_my[0], 10'h3FF);
    chk("t2_motion_x", 0, o_mx[0], 10'd0);
    chk("t2_pend_clr", 0, 10'(o_tp[0]), 10'd0);

    // 3) reversal at an unaligned position
    reset_pulse(10'd64, 10'd64);
    key = 8'h07;
    tick();
    key = 8'h00;
    tick();
    tick();
    chk("t3_at67", 0, px[0], 10'd67);
    key = 8'h04;
    tick();
    key = 8'h00;
    chk("t3_facing", 0, 10'(o_face[0]), 10'd0);
    chk("t3_motion_x", 0, o_mx[0], 10'h3FF);

    // 4) blocked by a wall at x=80, then resume downwards
    reset_pulse(10'd74, 10'd64);
    key = 8'h07;
    tick();
    key = 8'h00;
    for (int n = 0; n < 20 && px[0] != 10'd80; n++) tick();
    chk("t4_reach80", 0, px[0], 10'd80);
    wr = 1'b1;
    tick();
    chk("t4_moving", 0, 10'(o_mov[0]), 10'd0);
    chk("t4_motion_x", 0, o_mx[0], 10'd0);
    chk("t4_facing", 0, 10'(o_face[0]), 10'd1);
    tick();
    chk("t4_still", 0, o_mx[0], 10'd0);
    key = 8'h16;
    tick();
    key = 8'h00; wr = 1'b0;
    chk("t4_resume", 0, 10'(o_mov[0]), 10'd1);
    chk("t4_down", 0, 10'(o_face[0]), 10'd2);
    chk("t4_motion_y", 0, o_my[0], 10'd1);

    // 5) buffered turn expires against a wall (short-timeout instance)
    reset_pulse(10'd64, 10'd64);
    wd = 1'b1;
    key = 8'h16;
    tick();
    key = 8'h00;
    chk("t5_pend_set", 1, 10'(o_tp[1]), 10'd1);
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("t5_pend", 1, 10'(o_tp[1]), 10'(j < 4));
      chk("t5_noturn", 1, 10'(o_mov[1]), 10'd0);
    end
    wd = 1'b0;

    // 6) frame divider, pause, reset mid-move
    reset_pulse(10'd64, 10'd64);
    key = 8'h07;
    nz = 0;
    for (int j = 0; j < 9; j++) begin
      tick();
      chk("t6_div", 1, 10'(o_mx[1] != 10'd0), 10'(j % 3 == 0));
      if (o_mx[1] != 10'd0) nz++;
    end
    chk("t6_div_count", 1, 10'(nz), 10'd3);
    pause = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t6_pause_mx0", 0, o_mx[0], 10'd0);
      chk("t6_pause_mx1", 1, o_mx[1], 10'd0);
      chk("t6_pause_mov", 1, 10'(o_mov[1]), 10'd1);
    end
    pause = 1'b0;
    tick();
    chk("t6_resume_step", 1, o_mx[1], 10'd1);
    tick();
    chk("t6_resume_idle", 1, o_mx[1], 10'd0);
    reset_pulse(10'd64, 10'd64);
    chk("t6_rst_moving", 0, 10'(o_mov[0]), 10'd0);
    chk("t6_rst_mx", 0, o_mx[0], 10'd0);
    chk("t6_rst_facing", 1, 10'(o_face[1]), 10'd0);
    key = 8'h00;

    // randomized traffic against the model
    for (int n = 0; n < 700; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      key = 8'h00;
      else if (r < 80) key = dk[$urandom_range(0, 3)];
      else             key = 8'($urandom);
      wu = ($urandom_range(0, 3) == 0);
      wd = ($urandom_range(0, 3) == 0);
      wl = ($urandom_range(0, 3) == 0);
      wr = ($urandom_range(0, 3) == 0);
      pause = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) reset_pulse(10'd64, 10'd64);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
